// File: rtl/cpu_seq_if.sv
// cpu_seq_if: control bus between the CPU sequencer and the datapath.
//   master modport : sequencer side (samples run/opcode/mem_ready, drives strobes)
//   slave  modport : datapath side
// Signals: run, opcode[2:0], mem_ready -> sequencer
//          pc_en, ir_load, rf_rd_en, alu_en, alu_op[2:0], mem_req, mem_we,
//          rf_we, wb_sel, halted, mem_err, instr_count[CNT_W-1:0] <- sequencer
interface cpu_seq_if #(parameter int CNT_W = 16);
  logic             run;
  logic [2:0]       opcode;
  logic             mem_ready;
  logic             pc_en;
  logic             ir_load;
  logic             rf_rd_en;
  logic             alu_en;
  logic [2:0]       alu_op;
  logic             mem_req;
  logic             mem_we;
  logic             rf_we;
  logic             wb_sel;
  logic             halted;
  logic             mem_err;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  run, opcode, mem_ready,
    output pc_en, ir_load, rf_rd_en, alu_en, alu_op, mem_req, mem_we,
           rf_we, wb_sel, halted, mem_err, instr_count
  );

  modport slave (
    output run, opcode, mem_ready,
    input  pc_en, ir_load, rf_rd_en, alu_en, alu_op, mem_req, mem_we,
           rf_we, wb_sel, halted, mem_err, instr_count
  );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control FSM (IDLE/FETCH/DECODE/EXEC/MEM/WB/HALT)
// for the single-issue CPU. Drives datapath enables, waits on the data-memory
// ready handshake and counts retired instructions.
// Ports:
//   clk    - clock, posedge
//   rst_n  - asynchronous active-low reset
//   bus    - cpu_seq_if.master control bus (inputs run/opcode/mem_ready,
//            all strobes, halted, mem_err, instr_count)
// Parameters: CNT_W (instr_count width), MEM_TIMEOUT (MEM wait limit).
// Optional feature macro: CPU_SEQ_TIMEOUT_EN enables the MEM-stage timeout
// fault; without it MEM waits forever and mem_err is tied low.
module cpu_sequencer #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic     clk,
  input  logic     rst_n,
  cpu_seq_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LW   = 3'd5;
  localparam logic [2:0] OP_SW   = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  state_t           r_state, w_nxt;
  logic [2:0]       r_op, w_nxt_op;
  logic             w_retire, w_fault;
  logic [CNT_W-1:0] r_cnt;
  logic r_pc_en, r_ir_load, r_rf_rd_en, r_alu_en, r_mem_req, r_mem_we;
  logic r_rf_we, r_wb_sel, r_halted;

`ifdef CPU_SEQ_TIMEOUT_EN
  localparam int WT_W = $clog2(MEM_TIMEOUT + 1);
  logic [WT_W-1:0] r_wait;
  logic            r_mem_err;
  // Fault on the MEM cycle that would bring the wait count up to MEM_TIMEOUT.
  assign w_fault = (r_state == S_MEM) && !bus.mem_ready &&
                   (r_wait == WT_W'(MEM_TIMEOUT - 1));
  assign bus.mem_err = r_mem_err;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (MEM_TIMEOUT > 0);
  assign w_fault      = 1'b0;
  assign bus.mem_err  = 1'b0;
`endif

  always_comb begin
    w_nxt    = r_state;
    w_nxt_op = r_op;
    w_retire = 1'b0;
    case (r_state)
      S_IDLE:   if (bus.run) w_nxt = S_FETCH;
      S_FETCH:  w_nxt = S_DECODE;
      S_DECODE: begin
        w_nxt_op = bus.opcode;
        case (bus.opcode)
          OP_NOP:  w_retire = 1'b1;
          OP_HALT: w_nxt    = S_HALT;
          default: w_nxt    = S_EXEC;
        endcase
      end
      S_EXEC:   w_nxt = (r_op == OP_LW || r_op == OP_SW) ? S_MEM : S_WB;
      S_MEM: begin
        if (w_fault)            w_nxt = S_HALT;
        else if (bus.mem_ready) begin
          if (r_op == OP_SW) w_retire = 1'b1;
          else               w_nxt    = S_WB;
        end
      end
      S_WB:     w_retire = 1'b1;
      S_HALT:   w_nxt = S_HALT;
      default:  w_nxt = S_IDLE;
    endcase
    // run is only looked at when an instruction leaves the pipe.
    if (w_retire) w_nxt = bus.run ? S_FETCH : S_IDLE;
  end

  // Strobes are registered from the next state, so each one is a pure
  // function of the state/op_q it is valid in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_op       <= OP_NOP;
      r_cnt      <= '0;
      r_pc_en    <= 1'b0;
      r_ir_load  <= 1'b0;
      r_rf_rd_en <= 1'b0;
      r_alu_en   <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_rf_we    <= 1'b0;
      r_wb_sel   <= 1'b0;
      r_halted   <= 1'b0;
`ifdef CPU_SEQ_TIMEOUT_EN
      r_wait     <= '0;
      r_mem_err  <= 1'b0;
`endif
    end else begin
      r_state    <= w_nxt;
      r_op       <= w_nxt_op;
      if (w_retire) r_cnt <= r_cnt + 1'b1;
      r_pc_en    <= (w_nxt == S_FETCH);
      r_ir_load  <= (w_nxt == S_FETCH);
      r_rf_rd_en <= (w_nxt == S_DECODE);
      r_alu_en   <= (w_nxt == S_EXEC);
      r_mem_req  <= (w_nxt == S_MEM);
      r_mem_we   <= (w_nxt == S_MEM) && (w_nxt_op == OP_SW);
      r_rf_we    <= (w_nxt == S_WB);
      r_wb_sel   <= (w_nxt == S_WB) && (w_nxt_op == OP_LW);
      r_halted   <= (w_nxt == S_HALT);
`ifdef CPU_SEQ_TIMEOUT_EN
      if (w_nxt == S_MEM && r_state != S_MEM) r_wait <= '0;
      else if (r_state == S_MEM && !bus.mem_ready) r_wait <= r_wait + 1'b1;
      if (w_fault) r_mem_err <= 1'b1;
`endif
    end
  end

  assign bus.pc_en       = r_pc_en;
  assign bus.ir_load     = r_ir_load;
  assign bus.rf_rd_en    = r_rf_rd_en;
  assign bus.alu_en      = r_alu_en;
  assign bus.alu_op      = r_op;
  assign bus.mem_req     = r_mem_req;
  assign bus.mem_we      = r_mem_we;
  assign bus.rf_we       = r_rf_we;
  assign bus.wb_sel      = r_wb_sel;
  assign bus.halted      = r_halted;
  assign bus.instr_count = r_cnt;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: self-checking bench for cpu_sequencer. Programs are
// expanded from the instruction-level latency rules into a per-cycle schedule
// of inputs and expected outputs, which is then played against the DUT.
module tb_cpu_sequencer;
  localparam int CNT_W       = 16;
  localparam int MEM_TIMEOUT = 15;

  // Expected-output bit positions
  localparam int PC = 9, IR = 8, RD = 7, AL = 6, MQ = 5, MW = 4;
  localparam int WE = 3, WS = 2, HL = 1, ME = 0;
  localparam logic [9:0] O_IDLE  = 10'd0;
  localparam logic [9:0] O_FETCH = (10'd1 << PC) | (10'd1 << IR);
  localparam logic [9:0] O_DEC   = 10'd1 << RD;
  localparam logic [9:0] O_EXEC  = 10'd1 << AL;
  localparam logic [9:0] O_MEM   = 10'd1 << MQ;
  localparam logic [9:0] O_WB    = 10'd1 << WE;
  localparam logic [9:0] O_HALT  = 10'd1 << HL;

  typedef struct packed {
    logic             run;
    logic [2:0]       opc;
    logic             rdy;
    logic [9:0]       o;
    logic [2:0]       aop;
    logic [CNT_W-1:0] cnt;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_seq_if #(.CNT_W(CNT_W)) bus();
  cpu_sequencer #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  ent_t             sq[$];
  logic [2:0]       m_op;
  logic [CNT_W-1:0] m_cnt;
  int n_chk = 0, n_fail = 0;
  int pc_n, mq_n, mw_n, we_n;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction
  function automatic logic [2:0] r3();
    return 3'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] actv();
    return 32'({bus.pc_en, bus.ir_load, bus.rf_rd_en, bus.alu_en, bus.mem_req,
                bus.mem_we, bus.rf_we, bus.wb_sel, bus.halted, bus.mem_err,
                bus.alu_op, bus.instr_count});
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  task automatic push(input logic [9:0] o, input logic r, input logic [2:0] opc,
                      input logic rdy);
    ent_t e;
    e.run = r; e.opc = opc; e.rdy = rdy; e.o = o; e.aop = m_op; e.cnt = m_cnt;
    sq.push_back(e);
  endtask

  // n idle cycles; run held 0 until the last, which starts the next fetch
  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) push(O_IDLE, (i == n - 1), r3(), rb());
  endtask

  task automatic add_halt(input logic [9:0] o);
    for (int i = 0; i < 4; i++) push(o, rb(), r3(), rb());
  endtask

  // One instruction: op, w extra MEM waits, r = run at retire
  task automatic add_instr(input logic [2:0] op, input int w, input logic r);
    logic [9:0] mo;
    push(O_FETCH, rb(), r3(), rb());
    if (op == 3'd0) begin
      push(O_DEC, r, op, rb());
      m_op = op; m_cnt++;
    end else if (op == 3'd7) begin
      push(O_DEC, rb(), op, rb());
      m_op = op;
      add_halt(O_HALT);
      return;
    end else begin
      push(O_DEC, rb(), op, rb());
      m_op = op;
      push(O_EXEC, rb(), r3(), rb());
      if (op <= 3'd4) begin
        push(O_WB, r, r3(), rb());
        m_cnt++;
      end else begin
        mo = O_MEM | ((op == 3'd6) ? (10'd1 << MW) : 10'd0);
`ifdef CPU_SEQ_TIMEOUT_EN
        if (w >= MEM_TIMEOUT) begin
          for (int i = 0; i < MEM_TIMEOUT; i++) push(mo, rb(), r3(), 1'b0);
          add_halt(O_HALT | (10'd1 << ME));
          return;
        end
`endif
        for (int i = 0; i < w; i++) push(mo, rb(), r3(), 1'b0);
        if (op == 3'd6) begin
          push(mo, r, r3(), 1'b1);
          m_cnt++;
        end else begin
          push(mo, rb(), r3(), 1'b1);
          push(O_WB | (10'd1 << WS), r, r3(), rb());
          m_cnt++;
        end
      end
    end
    if (!r) add_idle($urandom_range(1, 3));
  endtask

  // Play up to lim schedule entries (lim < 0: all), one per clock
  task automatic run_sched(input int lim);
    ent_t e;
    int k = 0;
    pc_n = 0; mq_n = 0; mw_n = 0; we_n = 0;
    while (sq.size() > 0 && (lim < 0 || k < lim)) begin
      e = sq.pop_front();
      bus.run = e.run; bus.opcode = e.opc; bus.mem_ready = e.rdy;
      chk("cycle", actv(), 32'({e.o, e.aop, e.cnt}));
      pc_n += int'(bus.pc_en); mq_n += int'(bus.mem_req);
      mw_n += int'(bus.mem_we); we_n += int'(bus.rf_we);
      k++;
      @(posedge clk); #1;
    end
  endtask

  // Asserts reset mid-cycle, checks outputs cleared at once, releases it so
  // the following cycle is IDLE.
  task automatic do_reset();
    rst_n = 1'b0;
    bus.run = 1'b0; bus.opcode = 3'd1; bus.mem_ready = 1'b0;
    #1;
    chk("reset", actv(), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sq.delete();
    m_op = 3'd0; m_cnt = '0;
  endtask

  initial begin
    bus.run = 1'b1; bus.opcode = 3'd1; bus.mem_ready = 1'b0;
    m_op = 3'd0; m_cnt = '0;
    repeat (2) @(posedge clk);
    #1;

    // ADD straight out of reset
    do_reset();
    add_idle(1); add_instr(3'd1, 0, 1'b1); add_instr(3'd7, 0, 1'b0);
    run_sched(-1);
    chk("add_count", 32'(bus.instr_count), 32'd1);
    chk("add_rf_we", 32'(we_n), 32'd1);

    // LW with 3 extra waits
    do_reset();
    add_idle(1); add_instr(3'd5, 3, 1'b0);
    run_sched(-1);
    chk("lw_mem_req", 32'(mq_n), 32'd4);
    chk("lw_mem_we", 32'(mw_n), 32'd0);
    chk("lw_rf_we", 32'(we_n), 32'd1);
    chk("lw_count", 32'(bus.instr_count), 32'd1);

    // SW ready on first MEM cycle
    do_reset();
    add_idle(1); add_instr(3'd6, 0, 1'b1); add_instr(3'd7, 0, 1'b0);
    run_sched(-1);
    chk("sw_mem_req", 32'(mq_n), 32'd1);
    chk("sw_mem_we", 32'(mw_n), 32'd1);
    chk("sw_rf_we", 32'(we_n), 32'd0);

    // NOP, NOP, HALT
    do_reset();
    add_idle(1); add_instr(3'd0, 0, 1'b1); add_instr(3'd0, 0, 1'b1);
    add_instr(3'd7, 0, 1'b0);
    run_sched(-1);
    chk("nop_count", 32'(bus.instr_count), 32'd2);
    chk("nop_halted", 32'(bus.halted), 32'd1);
    chk("nop_pc_en", 32'(pc_n), 32'd3);

    // SUB with run dropped before retire
    do_reset();
    add_idle(1); add_instr(3'd2, 0, 1'b0);
    run_sched(-1);
    chk("sub_pc_en", 32'(pc_n), 32'd1);
    chk("sub_count", 32'(bus.instr_count), 32'd1);

`ifdef CPU_SEQ_TIMEOUT_EN
    // LW with mem_ready stuck low
    do_reset();
    add_idle(1); add_instr(3'd5, MEM_TIMEOUT, 1'b1);
    run_sched(-1);
    chk("to_mem_req", 32'(mq_n), 32'(MEM_TIMEOUT));
    chk("to_mem_err", 32'(bus.mem_err), 32'd1);
    chk("to_count", 32'(bus.instr_count), 32'd0);
`endif

    // Reset in the middle of MEM, then restart
    do_reset();
    add_idle(1); add_instr(3'd5, 6, 1'b1);
    run_sched(6);
    chk("mid_mem_req", 32'(bus.mem_req), 32'd1);
    do_reset();
    add_idle(1); add_instr(3'd1, 0, 1'b1); add_instr(3'd7, 0, 1'b0);
    run_sched(-1);
    chk("restart_count", 32'(bus.instr_count), 32'd1);

    // Random program
    do_reset();
    add_idle($urandom_range(1, 3));
    for (int i = 0; i < 250; i++)
      add_instr(3'($urandom_range(0, 6)), $urandom_range(0, 4),
                ($urandom_range(0, 3) != 0));
    add_instr(3'd7, 0, 1'b0);
    run_sched(-1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
